// File: rtl/spdif_pkg.sv
// S/PDIF transmitter constants: preambles, subframe slot map, frame/block geometry.
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam int SLOT_AUDIO_LSB = 4;
    localparam int SLOT_V         = 28;
    localparam int SLOT_U         = 29;
    localparam int SLOT_C         = 30;
    localparam int SLOT_P         = 31;

    localparam int UI_PER_SUBFRAME  = 64;
    localparam int FRAMES_PER_BLOCK = 192;

endpackage

// File: rtl/spdif_bmc_enc.sv
// Purpose: next biphase-mark line level for one unit interval (preamble or data slot).
// Latency: combinational; the caller registers the result on the tick edge.
// Backpressure: none, evaluated every cycle.
module spdif_bmc_enc
    import spdif_pkg::*;
(
    input  logic       i_prev_lvl,
    input  logic       i_pre_ref,
    input  logic [5:0] i_ui,
    input  logic [7:0] i_preamble,
    input  logic       i_bit,
    output logic       o_lvl
);

    logic w_in_pre;
    logic w_ref;

    assign w_in_pre = (i_ui < 6'(2 * SLOT_AUDIO_LSB));
    // Preamble patterns are relative to the level held just before UI 0.
    assign w_ref    = (i_ui == 6'd0) ? i_prev_lvl : i_pre_ref;

    always_comb begin
        o_lvl = i_prev_lvl;
        if (w_in_pre) begin
            o_lvl = i_preamble[~i_ui[2:0]] ^ w_ref;
        end else if (!i_ui[0]) begin
            o_lvl = ~i_prev_lvl;
        end else begin
            o_lvl = i_prev_lvl ^ i_bit;
        end
    end

endmodule

// File: rtl/spdif_tx.sv
// Purpose: S/PDIF subframe/frame sequencer with one-entry sample-pair holding buffer.
// Latency: spdif_out changes on the same clk_in edge that samples tick.
// Backpressure: in_ready low while the buffer holds a pair; drained at each frame start.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter logic [31:0] CS_LOW = 32'h0000_0004
)
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [23:0] left_in,
    input  logic [23:0] right_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        spdif_out,
    output logic        block_start,
    output logic        underrun
);

    logic [5:0]  r_ui;
    logic        r_right;
    logic [7:0]  r_frame;
    logic        r_buf_full;
    logic [23:0] r_buf_l;
    logic [23:0] r_buf_r;
    logic [23:0] r_smp_l;
    logic [23:0] r_smp_r;
    logic        r_v;
    logic        r_lvl;
    logic        r_pre_lvl;
    logic        r_block_start;
    logic        r_underrun;

    logic        w_xfer;
    logic        w_consume;
    logic [4:0]  w_slot;
    logic [4:0]  w_aidx;
    logic [23:0] w_sample;
    logic        w_c;
    logic        w_par;
    logic        w_bit;
    logic [7:0]  w_preamble;
    logic        w_lvl_next;

    assign w_xfer    = in_valid && !r_buf_full;
    assign w_consume = tick && (r_ui == 6'd0) && !r_right;
    assign w_slot    = r_ui[5:1];
    assign w_aidx    = w_slot - 5'(SLOT_AUDIO_LSB);
    assign w_sample  = r_right ? r_smp_r : r_smp_l;
    assign w_c       = (r_frame < 8'd32) ? CS_LOW[r_frame[4:0]] : 1'b0;
    // Even parity over audio, V, U (always 0) and C.
    assign w_par     = (^w_sample) ^ r_v ^ w_c;

    always_comb begin
        w_preamble = PRE_W;
        if (!r_right) begin
            w_preamble = (r_frame == 8'd0) ? PRE_B : PRE_M;
        end
    end

    always_comb begin
        w_bit = 1'b0;
        if (w_slot == 5'(SLOT_V)) begin
            w_bit = r_v;
        end else if (w_slot == 5'(SLOT_C)) begin
            w_bit = w_c;
        end else if (w_slot == 5'(SLOT_P)) begin
            w_bit = w_par;
        end else if (w_slot >= 5'(SLOT_AUDIO_LSB) && w_slot < 5'(SLOT_V)) begin
            w_bit = w_sample[w_aidx];
        end
    end

    spdif_bmc_enc u_bmc_enc (
        .i_prev_lvl (r_lvl),
        .i_pre_ref  (r_pre_lvl),
        .i_ui       (r_ui),
        .i_preamble (w_preamble),
        .i_bit      (w_bit),
        .o_lvl      (w_lvl_next)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ui          <= 6'd0;
            r_right       <= 1'b0;
            r_frame       <= 8'd0;
            r_buf_full    <= 1'b0;
            r_buf_l       <= 24'd0;
            r_buf_r       <= 24'd0;
            r_smp_l       <= 24'd0;
            r_smp_r       <= 24'd0;
            r_v           <= 1'b0;
            r_lvl         <= 1'b0;
            r_pre_lvl     <= 1'b0;
            r_block_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_block_start <= 1'b0;
            r_underrun    <= 1'b0;
            // A pair offered while an empty buffer is consumed lands for the next frame.
            if (w_consume) begin
                r_buf_full    <= w_xfer;
                r_smp_l       <= r_buf_full ? r_buf_l : 24'd0;
                r_smp_r       <= r_buf_full ? r_buf_r : 24'd0;
                r_v           <= !r_buf_full;
                r_underrun    <= !r_buf_full;
                r_block_start <= (r_frame == 8'd0);
            end else if (w_xfer) begin
                r_buf_full <= 1'b1;
            end
            if (w_xfer) begin
                r_buf_l <= left_in;
                r_buf_r <= right_in;
            end
            if (tick) begin
                r_lvl <= w_lvl_next;
                if (r_ui == 6'd0) begin
                    r_pre_lvl <= r_lvl;
                end
                r_ui <= r_ui + 6'd1;
                if (r_ui == 6'(UI_PER_SUBFRAME - 1)) begin
                    r_right <= ~r_right;
                    if (r_right) begin
                        r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frame + 8'd1;
                    end
                end
            end
        end
    end

    assign in_ready    = !r_buf_full;
    assign spdif_out   = r_lvl;
    assign block_start = r_block_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_spdif_tx.sv
// Bench for spdif_tx: subframe-level reference model plus directed scenarios.
module tb_spdif_tx;

    localparam logic [31:0] CS_TB = 32'h8C31_0A04;
    localparam logic [7:0]  TB_B  = 8'b1110_1000;
    localparam logic [7:0]  TB_M  = 8'b1110_0010;
    localparam logic [7:0]  TB_W  = 8'b1110_0100;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        tick   = 1'b0;
    logic [23:0] left_in  = 24'd0;
    logic [23:0] right_in = 24'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        spdif_out;
    logic        block_start;
    logic        underrun;

    spdif_tx #(.CS_LOW(CS_TB)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .tick        (tick),
        .left_in     (left_in),
        .right_in    (right_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .spdif_out   (spdif_out),
        .block_start (block_start),
        .underrun    (underrun)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ui;
    bit          m_right;
    int          m_frame;
    bit          m_full;
    logic [23:0] m_bl, m_br, m_cur_l, m_cur_r;
    bit          m_v;
    bit          m_lvl;
    bit          exp_bs, exp_ur;
    bit          sf[64];
    int          tick_cnt;

    logic [23:0] src_l[$];
    logic [23:0] src_r[$];
    bit          cap[$];
    int          bs_ticks[$];
    int          ur_cnt;
    int          held_cnt;
    bit          rst_want;
    bit          feed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ui = 0; m_right = 0; m_frame = 0; m_full = 0;
        m_bl = 0; m_br = 0; m_cur_l = 0; m_cur_r = 0;
        m_v = 0; m_lvl = 0; exp_bs = 0; exp_ur = 0; tick_cnt = 0;
    endtask

    // Whole-subframe waveform from the slot contents and the starting level.
    task automatic build_subframe(input logic [23:0] smp, input bit v, input bit c,
                                  input logic [7:0] pre, input bit ref_lvl);
        bit slots[32];
        bit lvl;
        int ones;
        ones = $countones(smp) + int'(v) + int'(c);
        for (int s = 0; s < 32; s++) slots[s] = 1'b0;
        for (int s = 4; s < 28; s++) slots[s] = smp[s-4];
        slots[28] = v;
        slots[30] = c;
        slots[31] = bit'(ones % 2);
        for (int k = 0; k < 8; k++) sf[k] = pre[7-k] ^ ref_lvl;
        lvl = sf[7];
        for (int s = 4; s < 32; s++) begin
            lvl = ~lvl;
            sf[2*s] = lvl;
            if (slots[s]) lvl = ~lvl;
            sf[2*s+1] = lvl;
        end
    endtask

    task automatic model_step(input bit t, input bit v_in, input logic [23:0] l,
                              input logic [23:0] r, output bit xfer);
        logic [7:0] pre;
        bit c;
        exp_bs = 0;
        exp_ur = 0;
        xfer = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            xfer = v_in && !m_full;
            if (t) begin
                if (m_ui == 0) begin
                    if (!m_right) begin
                        if (m_full) begin
                            m_cur_l = m_bl; m_cur_r = m_br; m_v = 0; m_full = 0;
                        end else begin
                            m_cur_l = 0; m_cur_r = 0; m_v = 1; exp_ur = 1;
                        end
                        exp_bs = (m_frame == 0);
                    end
                    pre = m_right ? TB_W : ((m_frame == 0) ? TB_B : TB_M);
                    c = (m_frame < 32) ? CS_TB[m_frame] : 1'b0;
                    build_subframe(m_right ? m_cur_r : m_cur_l, m_v, c, pre, m_lvl);
                end
                m_lvl = sf[m_ui];
                tick_cnt++;
                m_ui++;
                if (m_ui == 64) begin
                    m_ui = 0;
                    if (m_right) m_frame = (m_frame + 1) % 192;
                    m_right = ~m_right;
                end
            end
            if (xfer) begin
                m_bl = l; m_br = r; m_full = 1;
            end
        end
    endtask

    task automatic cyc(input bit t);
        bit xfer;
        @(negedge clk_in);
        if (feed && src_l.size() == 0) begin
            src_l.push_back(24'($urandom));
            src_r.push_back(24'($urandom));
        end
        rst_n    = rst_want;
        tick     = t;
        in_valid = (src_l.size() > 0);
        left_in  = in_valid ? src_l[0] : 24'd0;
        right_in = in_valid ? src_r[0] : 24'd0;
        if (in_valid && !in_ready) held_cnt++;
        @(posedge clk_in);
        model_step(t, in_valid, left_in, right_in, xfer);
        if (xfer) begin
            void'(src_l.pop_front());
            void'(src_r.pop_front());
        end
        #1;
        chk("spdif_out", spdif_out, m_lvl);
        chk("in_ready", in_ready, !m_full);
        chk("block_start", block_start, exp_bs);
        chk("underrun", underrun, exp_ur);
        if (t && rst_n) cap.push_back(spdif_out);
        if (underrun) ur_cnt++;
        if (block_start) bs_ticks.push_back(tick_cnt);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            cyc(1'b0);
            if ($urandom_range(0, 3) == 0) cyc(1'b0);
        end
    endtask

    function automatic logic [7:0] cap8(input int base);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = cap[base+k];
        return v;
    endfunction

    function automatic logic cap_pair_xor(input int base);
        return cap[base] ^ cap[base+1];
    endfunction

    initial begin
        model_reset();
        rst_want = 0;
        feed = 0;
        #1 rst_n = 1'b0;

        // Reset held with ticks running
        for (int i = 0; i < 8; i++) begin
            cyc(bit'(i % 2));
            chk("rst_spdif_out", spdif_out, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
            chk("rst_pulses", {block_start, underrun}, 2'b00);
        end

        // First frame carries left=1, right=0; then three starved frames
        rst_want = 1;
        src_l.push_back(24'h000001);
        src_r.push_back(24'h000000);
        cyc(1'b0);
        cap.delete();
        ur_cnt = 0;
        run_ticks(128);
        chk("f0_left_preamble", cap8(0), 8'b1110_1000);
        chk("f0_slot4", {cap[8], cap[9]}, 2'b10);
        chk("f0_left_V", cap_pair_xor(56), 1'b0);
        chk("f0_left_P", cap_pair_xor(62), 1'b1);
        chk("f0_right_preamble", cap8(64), 8'b1110_0100);
        chk("f0_right_P", cap_pair_xor(126), 1'b0);
        run_ticks(384);
        chk("starved_underruns", ur_cnt, 3);
        chk("f1_left_V", cap_pair_xor(128 + 56), 1'b1);

        // Two back-to-back pairs offered mid-frame
        run_ticks(64);
        ur_cnt = 0;
        held_cnt = 0;
        src_l.push_back(24'h123456); src_r.push_back(24'hFEDCBA);
        src_l.push_back(24'h800000); src_r.push_back(24'h7FFFFF);
        run_ticks(256);
        chk("b2b_underruns", ur_cnt, 0);
        chk("b2b_held", held_cnt > 0, 1'b1);
        chk("b2b_accepted", src_l.size(), 0);

        // Asynchronous reset at u=37 of a right subframe
        for (int i = 0; i < 300 && !(m_right && m_ui == 38); i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        chk("reached_right_u37", (m_right && m_ui == 38), 1'b1);
        #2;
        rst_want = 0;
        rst_n = 1'b0;
        #1;
        chk("async_spdif_out", spdif_out, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end

        // Continuous supply across a full block wrap
        rst_want = 1;
        feed = 1;
        cyc(1'b0);
        cap.delete();
        bs_ticks.delete();
        ur_cnt = 0;
        run_ticks(193 * 128 + 8);
        chk("cont_underruns", ur_cnt, 0);
        chk("post_reset_B", cap8(0), 8'b1110_1000);
        chk("f1_M", cap8(128), 8'b1110_0010);
        chk("f0_W", cap8(64), 8'b1110_0100);
        chk("f192_B", cap8(192 * 128), 8'b1110_1000);
        chk("C_f0", cap_pair_xor(60), 1'b0);
        chk("C_f2", cap_pair_xor(2 * 128 + 60), 1'b1);
        chk("C_f2_right", cap_pair_xor(2 * 128 + 64 + 60), 1'b1);
        chk("C_f31", cap_pair_xor(31 * 128 + 60), 1'b1);
        chk("C_f40", cap_pair_xor(40 * 128 + 60), 1'b0);
        chk("block_start_count", bs_ticks.size(), 2);
        if (bs_ticks.size() == 2) begin
            chk("block_start_period", bs_ticks[1] - bs_ticks[0], 24576);
        end else begin
            chk("block_start_period_avail", bs_ticks.size(), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spdif_tx.md
SPDIF_TX -- requirements
Module: spdif_tx

Interface
REQ-001 SHALL have parameter CS_LOW, default 32'h0000_0004, channel-status bits 0..31 (bit i sent in frame i); bits 32..191 SHALL be 0.
REQ-002 SHALL have port clk_in  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tick  input  1  unit-interval (UI) strobe at 128*fs, one clk_in cycle wide.
REQ-005 SHALL have port left_in  input  24  left sample, two's complement.
REQ-006 SHALL have port right_in  input  24  right sample, two's complement.
REQ-007 SHALL have port in_valid  input  1  sample pair offered.
REQ-008 SHALL have port in_ready  output  1  holding buffer empty; transfer when in_valid && in_ready.
REQ-009 SHALL have port spdif_out  output  1  biphase-mark (BMC) line output.
REQ-010 SHALL have port block_start  output  1  one-cycle pulse at first UI of frame 0.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with an empty buffer.

Function
REQ-012 SHALL advance state only on clk_in edges with tick=1; spdif_out updates on that same edge, so latency from tick is one clk_in edge.
REQ-013 SHALL count UI u 0..63 per subframe; slot = u>>1; subframe order left then right; frame counter 0..191, wrapping 191->0.
REQ-014 Slots: 0-3 preamble, 4-27 audio LSB first, 28 V, 29 U=0, 30 C, 31 P = even parity over slots 4-30.
REQ-015 Preambles, 8 UI MSB first, prior level 0: B=8'b11101000 (left, frame 0), M=8'b11100010 (other left), W=8'b11100100 (right).
REQ-016 During slots 0-3, spdif_out = pattern[u] XOR L, where L is spdif_out latched just before u=0.
REQ-017 For slots 4-31, spdif_out SHALL toggle at the even UI and also toggle at the odd UI iff the slot bit is 1.
REQ-018 One-entry holding buffer: in_ready = buffer empty; a transfer fills it with left_in and right_in.
REQ-019 On the tick with u=0 of a left subframe, the buffer is consumed into the shift registers and emptied; V=0.
REQ-020 If the buffer is empty at that tick, the frame SHALL carry zero audio with V=1 in both subframes, and underrun SHALL pulse.
REQ-021 A transfer coincident with a consume of an empty buffer SHALL fill the buffer for the next frame; the current frame is an underrun.
REQ-022 C in frame n SHALL be CS_LOW[n] for n<32, else 0; both subframes carry the same C.
REQ-023 block_start SHALL pulse on the tick emitting UI 0 of frame 0.
REQ-024 If tick arrives while the previous tick is being processed, the tick SHALL NOT be dropped; tick is guaranteed at most every 2 clk_in cycles.

Reset
REQ-025 While rst_n=0: spdif_out=0, in_ready=1, block_start=0, underrun=0, buffer empty, u=0, left subframe, frame=0.
REQ-026 Reset mid-subframe SHALL abort immediately; the first tick after release SHALL emit B preamble UI 0.

Structure
REQ-027 Package spdif_pkg SHALL hold the preamble constants B/M/W, slot indices (AUDIO_LSB=4, V=28, U=29, C=30, P=31), UI_PER_SUBFRAME=64 and FRAMES_PER_BLOCK=192.
REQ-028 Sub-module spdif_bmc_enc SHALL implement the level update for one UI (preamble XOR / toggle rules).

Verification
REQ-029 Reset with ticks running -> spdif_out=0, in_ready=1, no pulses until rst_n=1.
REQ-030 Load left=24'h000001, right=0, first frame -> left UIs 0-7 = 11101000, slot 4 = "10", P=1; right preamble = 11100100.
REQ-031 No in_valid -> every frame all-zero audio, V=1, underrun pulses once per frame (every 128 ticks).
REQ-032 Continuous supply for 400 frames -> block_start every 24576 ticks; B only in frame 0, M otherwise; C matches CS_LOW in frames 0..31.
REQ-033 Two back-to-back in_valid pairs -> second held (in_ready=0) until the next frame start, then accepted; no underrun.
REQ-034 rst_n pulsed low at u=37 of a right subframe -> spdif_out=0 asynchronously; after release, frame 0 B preamble; parity correct throughout.
